// File: rtl/instr_fetch_unit.sv
// Instruction fetch responder: req/ack read of program memory into IR.
// Watchdog-bounded wait; PC redirects are deferred while a read is in flight.
module instr_fetch_unit #(
  parameter int unsigned          ADDR_W     = 8,
  parameter int unsigned          DATA_W     = 8,
  parameter logic [ADDR_W-1:0]    RESET_PC   = '0,
  parameter int unsigned          TIMEOUT    = 16,
  parameter logic [DATA_W-1:0]    ERR_OPCODE = 8'hFF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ir_load,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_value,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic              busy,
  output logic              fetch_err,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_req,
  input  logic              mem_rd_ack,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_pend_pc;
  logic               r_pend;
  logic [DATA_W-1:0]  r_ir;
  logic               r_ir_valid;
  logic               r_err;
  logic               r_req;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_tmo;
  logic [ADDR_W-1:0]  w_exit_pc;

  assign w_tmo = (r_cnt == CNT_LAST);

  // Newest redirect wins, including one arriving on the exit cycle itself.
  always_comb begin
    w_exit_pc = r_pc;
    if (pc_load)
      w_exit_pc = pc_load_value;
    else if (r_pend)
      w_exit_pc = r_pend_pc;
    else if (mem_rd_ack)
      w_exit_pc = r_pc + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_pend_pc  <= '0;
      r_pend     <= 1'b0;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_err      <= 1'b0;
      r_req      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_ir_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (pc_load)
            r_pc <= pc_load_value;
          if (ir_load) begin
            r_state <= REQ;
            r_req   <= 1'b1;
            r_cnt   <= '0;
            r_err   <= 1'b0;
          end
        end
        REQ: begin
          if (pc_load) begin
            r_pend    <= 1'b1;
            r_pend_pc <= pc_load_value;
          end
          if (mem_rd_ack || w_tmo) begin
            r_state    <= DONE;
            r_req      <= 1'b0;
            r_ir_valid <= 1'b1;
            r_pend     <= 1'b0;
            r_pc       <= w_exit_pc;
            if (mem_rd_ack) begin
              r_ir <= mem_rd_data;
            end else begin
              r_ir  <= ERR_OPCODE;
              r_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (pc_load)
            r_pc <= pc_load_value;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ir         = r_ir;
  assign ir_valid   = r_ir_valid;
  assign busy       = (r_state != IDLE);
  assign fetch_err  = r_err;
  assign pc         = r_pc;
  assign mem_addr   = r_pc;
  assign mem_rd_req = r_req;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit.
// Steps drive inputs 1ns after a rising edge and check there.
module tb_instr_fetch_unit;

  logic       clock;
  logic       reset;
  logic       ir_load;
  logic       pc_load;
  logic [7:0] pc_load_value;
  logic [7:0] ir;
  logic       ir_valid;
  logic       busy;
  logic       fetch_err;
  logic [7:0] pc;
  logic [7:0] mem_addr;
  logic       mem_rd_req;
  logic       mem_rd_ack;
  logic [7:0] mem_rd_data;

  int total = 0;
  int bad   = 0;
  int vcnt  = 0;

  instr_fetch_unit dut (
    .clock         (clock),
    .reset         (reset),
    .ir_load       (ir_load),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value),
    .ir            (ir),
    .ir_valid      (ir_valid),
    .busy          (busy),
    .fetch_err     (fetch_err),
    .pc            (pc),
    .mem_addr      (mem_addr),
    .mem_rd_req    (mem_rd_req),
    .mem_rd_ack    (mem_rd_ack),
    .mem_rd_data   (mem_rd_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock)
    if (ir_valid === 1'b1) vcnt++;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int v0;
    time t_prev;
    reset = 1'b1;
    ir_load = 1'b0;
    pc_load = 1'b0;
    pc_load_value = 8'h00;
    mem_rd_ack = 1'b0;
    mem_rd_data = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_pc", pc, 8'h00);
    chk("rst_ir", ir, 8'h00);
    chk("rst_valid", ir_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", fetch_err, 1'b0);
    chk("rst_req", mem_rd_req, 1'b0);

    // zero-wait fetch
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    chk("t1_req", mem_rd_req, 1'b1);
    chk("t1_addr", mem_addr, 8'h00);
    chk("t1_busy", busy, 1'b1);
    mem_rd_ack = 1'b1;
    mem_rd_data = 8'h05;
    tick();
    mem_rd_ack = 1'b0;
    chk("t1_ir", ir, 8'h05);
    chk("t1_valid", ir_valid, 1'b1);
    chk("t1_pc", pc, 8'h01);
    tick();
    chk("t1_idle_busy", busy, 1'b0);
    chk("t1_idle_valid", ir_valid, 1'b0);

    // delayed ack, ir_load re-pulsed while busy
    v0 = vcnt;
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_req", mem_rd_req, 1'b1);
      chk("t2_addr", mem_addr, 8'h01);
      ir_load = (i == 1);
      tick();
    end
    ir_load = 1'b0;
    chk("t2_addr_last", mem_addr, 8'h01);
    mem_rd_ack = 1'b1;
    mem_rd_data = 8'h0B;
    tick();
    mem_rd_ack = 1'b0;
    chk("t2_ir", ir, 8'h0B);
    chk("t2_valid", ir_valid, 1'b1);
    chk("t2_pc", pc, 8'h02);
    tick();
    tick();
    chk("t2_no_queue", busy, 1'b0);
    chk("t2_no_queue_req", mem_rd_req, 1'b0);
    chk("t2_vcount", vcnt - v0, 1);

    // timeout
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    n = 0;
    while (mem_rd_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("t3_req_cycles", n, 16);
    chk("t3_ir", ir, 8'hFF);
    chk("t3_err", fetch_err, 1'b1);
    chk("t3_valid", ir_valid, 1'b1);
    chk("t3_pc", pc, 8'h02);
    tick();
    chk("t3_err_hold", fetch_err, 1'b1);
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    chk("t3_err_clr", fetch_err, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk("t3_req_16th", mem_rd_req, 1'b1);
    mem_rd_ack = 1'b1;
    mem_rd_data = 8'h3C;
    tick();
    mem_rd_ack = 1'b0;
    chk("t3_late_ir", ir, 8'h3C);
    chk("t3_late_err", fetch_err, 1'b0);
    chk("t3_late_pc", pc, 8'h03);
    tick();

    // pc wrap and deferred redirect
    pc_load = 1'b1;
    pc_load_value = 8'hFF;
    tick();
    pc_load = 1'b0;
    chk("t4_pcload", pc, 8'hFF);
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    chk("t4_addr_ff", mem_addr, 8'hFF);
    mem_rd_ack = 1'b1;
    mem_rd_data = 8'h11;
    tick();
    mem_rd_ack = 1'b0;
    chk("t4_wrap", pc, 8'h00);
    tick();
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    pc_load = 1'b1;
    pc_load_value = 8'h40;
    tick();
    pc_load = 1'b0;
    chk("t4_addr_stable", mem_addr, 8'h00);
    mem_rd_ack = 1'b1;
    mem_rd_data = 8'h22;
    tick();
    mem_rd_ack = 1'b0;
    chk("t4_redirect", pc, 8'h40);
    chk("t4_ir", ir, 8'h22);
    tick();
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    chk("t4_addr_40", mem_addr, 8'h40);
    mem_rd_ack = 1'b1;
    mem_rd_data = 8'h33;
    tick();
    mem_rd_ack = 1'b0;
    chk("t4_pc_41", pc, 8'h41);
    tick();

    // reset during REQ, late ack ignored
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_req_drop", mem_rd_req, 1'b0);
    mem_rd_ack = 1'b1;
    mem_rd_data = 8'h55;
    tick();
    mem_rd_ack = 1'b0;
    chk("t5_ir", ir, 8'h00);
    chk("t5_valid", ir_valid, 1'b0);
    chk("t5_pc", pc, 8'h00);
    chk("t5_busy", busy, 1'b0);

    // back-to-back fetches
    t_prev = 0;
    for (int k = 1; k <= 5; k++) begin
      ir_load = 1'b1;
      tick();
      ir_load = 1'b0;
      mem_rd_ack = 1'b1;
      mem_rd_data = 8'(k);
      tick();
      mem_rd_ack = 1'b0;
      chk("t6_valid", ir_valid, 1'b1);
      chk("t6_ir", ir, k);
      if (k > 1) chk("t6_cadence", 32'($time - t_prev), 30);
      t_prev = $time;
      tick();
    end
    chk("t6_pc", pc, 8'h05);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
